sha512_msg_schedule: RTL
========================

// Module: sha512_msg_schedule
// PURPOSE
//  SHA-512 message-schedule stage. Accepts one padded 1024-bit block, emits W0..W79 one word per handshake.
//  Sits directly upstream of the round datapath (ch/ma/sum_A/sum_E/add_mod64), which consumes W_t in round t.
//  Holds a 16-word sliding window; W16..W79 are computed on the fly with small sigma0/sigma1.
// PARAMETERS
//  WORDS   80   number of schedule words emitted per block (fixed by SHA-512; 17..80 allowed for test)
//  IDX_W   7    width of w_idx; must satisfy 2**IDX_W >= WORDS
// PORTS
//  clk        in   1     rising-edge clock
//  rst_n      in   1     asynchronous active-low reset
//  sched_clr  in   1     synchronous abort: discard current block, return to IDLE
//  blk_valid  in   1     block available on blk_data
//  blk_ready  out  1     stage can accept a block
//  blk_data   in   1024  padded block, big-endian: M0 = blk_data[1023:960] ... M15 = blk_data[63:0]
//  w_valid    out  1     w_data holds W_t
//  w_ready    in   1     round stage consumes W_t this cycle
//  w_data     out  64    W_t
//  w_idx      out  IDX_W t of current word (0..WORDS-1)
//  w_last     out  1     high with w_valid when t == WORDS-1
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE, blk_ready=1, w_valid=0, w_data=0, w_idx=0, w_last=0, window cleared.
//  States: IDLE -> RUN on blk_valid&blk_ready; RUN -> IDLE on w_valid&w_ready&w_last; any -> IDLE on sched_clr.
//  IDLE: blk_ready=1, w_valid=0. Accept captures M0..M15 into window[0..15]; t=0.
//  RUN: blk_ready=0 (see CONFIGURATION); w_valid=1; w_data=window[0]; w_idx=t; w_last=(t==WORDS-1).
//  Latency: block accepted in cycle N -> w_valid=1, W0 on w_data in cycle N+1.
//  Handshake: word transfers on w_valid&w_ready; w_data/w_idx held stable while w_valid&!w_ready.
//  On transfer: window[i]<=window[i+1] for i=0..14; window[15]<=Wnew; t<=t+1.
//  Wnew = sig1(window[14]) + window[9] + sig0(window[1]) + window[0], mod 2^64 (carry out dropped).
//   sig0(x) = ROTR1(x) ^ ROTR8(x) ^ SHR7(x);  sig1(x) = ROTR19(x) ^ ROTR61(x) ^ SHR6(x).
//  Wnew computed for all t; words shifted in after t>=WORDS-16 are never emitted (don't-care).
//  Full throughput: one W_t per cycle while w_ready=1; 80 cycles per block plus 1 IDLE cycle.
//  sched_clr has priority over any handshake in the same cycle; w_valid=0 the next cycle.
//  blk_valid while in RUN is ignored (blk_ready=0); upstream must hold blk_data until accepted.
//  Reset mid-block: all state discarded immediately; no partial words emitted after release.
// CONFIGURATION
//  SHA512_SCHED_B2B_EN defined: blk_ready also high in RUN when w_valid&w_ready&w_last;
//   a block accepted in that cycle loads the window and sets t=0, so W0 of block k+1 follows W79 of block k
//   with zero bubble (80 cycles/block). sched_clr in the same cycle still wins: block not accepted.
//  Not defined: blk_ready = (state==IDLE) only; one idle cycle between blocks.
// TESTING
//  1. "abc" block (M0=64'h6162638000000000, M1..M14=0, M15=64'h18), w_ready=1 -> W0..W15 = M, W16=64'h6162638000000000,
//     W17=64'h00030000000000C0, w_idx 0..79 consecutive, w_last only at idx 79; all 80 words match FIPS 180-4 model.
//  2. Backpressure: toggle w_ready random 50% during block 1 -> same 80-word sequence, w_data stable while stalled.
//  3. Back-to-back blocks, blk_valid held high -> without SHA512_SCHED_B2B_EN 1-cycle gap after w_last;
//     with it, W0 of block 2 in the cycle after W79 of block 1; both blocks' words correct.
//  4. sched_clr asserted at t=37 with w_ready=1 -> next cycle w_valid=0, blk_ready=1; next block starts at w_idx=0.
//  5. rst_n low at t=50 (asynchronous, mid-cycle) -> outputs at reset values immediately; after release, new block emits correct W0.
//  6. Carry wrap: M chosen all 64'hFFFFFFFFFFFFFFFF -> W16 equals model sum mod 2^64 (no carry leakage).

Source files
------------

// File: rtl/sha512_msg_schedule.sv
// SHA-512 message schedule: loads one 1024-bit block, streams W0..W(WORDS-1) over a valid/ready link.
// Optional SHA512_SCHED_B2B_EN: accept the next block in the same cycle as the last word, for zero-bubble streaming.
module sha512_msg_schedule #(
  parameter int unsigned WORDS = 80,
  parameter int unsigned IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sched_clr,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [1023:0]    blk_data,
  output logic             w_valid,
  input  logic             w_ready,
  output logic [63:0]      w_data,
  output logic [IDX_W-1:0] w_idx,
  output logic             w_last
);

  localparam int unsigned WIN = 16;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [63:0]      window [WIN];
  logic [IDX_W-1:0] t_q;
  logic [63:0]      w_new;
  logic             accept;
  logic             xfer;

  function automatic logic [63:0] sig0(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sig1(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  assign w_new  = sig1(window[14]) + window[9] + sig0(window[1]) + window[0];
  assign accept = blk_valid && blk_ready && !sched_clr;
  assign xfer   = w_valid && w_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: abort beats a new block, a new block beats end-of-block
  always_comb begin
    state_nxt = state;
    if (sched_clr) begin
      state_nxt = IDLE;
    end else if (accept) begin
      state_nxt = RUN;
    end else if (xfer && w_last) begin
      state_nxt = IDLE;
    end
  end

  // Output decode from state and the word counter
  always_comb begin
    w_valid = (state == RUN);
    w_last  = (state == RUN) && (t_q == IDX_W'(WORDS - 1));
    w_data  = window[0];
    w_idx   = t_q;
`ifdef SHA512_SCHED_B2B_EN
    blk_ready = (state == IDLE) ||
                ((state == RUN) && w_ready && (t_q == IDX_W'(WORDS - 1)));
`else
    blk_ready = (state == IDLE);
`endif
  end

  // Sliding window and word index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q <= '0;
      for (int unsigned i = 0; i < WIN; i++) begin
        window[i] <= '0;
      end
    end else if (sched_clr) begin
      t_q <= '0;
    end else if (accept) begin
      t_q <= '0;
      for (int unsigned i = 0; i < WIN; i++) begin
        window[i] <= blk_data[1023 - 64*i -: 64];
      end
    end else if (xfer) begin
      t_q <= t_q + IDX_W'(1);
      for (int unsigned i = 0; i < WIN - 1; i++) begin
        window[i] <= window[i + 1];
      end
      window[WIN-1] <= w_new;
    end
  end

endmodule
